// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target endpoint, 7-bit address, open-drain SDA, byte handshake to local logic
module i2c_target #(
  parameter logic [6:0] TGT_ADDR = 7'h50
) (
  input  logic       clk_i,
  input  logic       rst_i,
  inout  wire        sda_io,
  inout  wire        scl_io,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_req_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {IDLE, ADDR, A_ACK, WDATA, W_ACK, RDATA, R_ACK, IGNORE} state_t;

  state_t     state;
  logic       scl_m, scl_s, scl_p;
  logic       sda_m, sda_s, sda_p;
  logic [2:0] cnt;
  logic [7:0] sr;
  logic       full;
  logic       rw;
  logic       acked;
  logic       mack;
  logic       sda_low;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] rbit;

  assign sda_io = sda_low ? 1'b0 : 1'bz;
  assign scl_io = 1'bz;

  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
  // after k bits have been clocked out, the next one to drive is bit 7-k
  assign rbit      = 3'd7 - cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      scl_m      <= 1'b1;
      scl_s      <= 1'b1;
      scl_p      <= 1'b1;
      sda_m      <= 1'b1;
      sda_s      <= 1'b1;
      sda_p      <= 1'b1;
      cnt        <= 3'd0;
      sr         <= 8'h00;
      full       <= 1'b0;
      rw         <= 1'b0;
      acked      <= 1'b0;
      mack       <= 1'b0;
      sda_low    <= 1'b0;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      tx_req_o   <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      scl_m      <= scl_io;
      scl_s      <= scl_m;
      scl_p      <= scl_s;
      sda_m      <= sda_io;
      sda_s      <= sda_m;
      sda_p      <= sda_s;
      rx_valid_o <= 1'b0;
      tx_req_o   <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        cnt     <= 3'd0;
        full    <= 1'b0;
        sda_low <= 1'b0;
        busy_o  <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        sda_low <= 1'b0;
        stop_o  <= busy_o;
        busy_o  <= 1'b0;
      end else begin
        if (scl_rise && (state == ADDR || state == WDATA || state == RDATA)) begin
          cnt  <= cnt + 3'd1;
          full <= (cnt == 3'd7);
          if (state != RDATA)
            sr <= {sr[6:0], sda_s};
        end
        if (scl_rise && state == R_ACK)
          mack <= ~sda_s;
        if (scl_fall) begin
          case (state)
            ADDR: if (full) begin
              full <= 1'b0;
              if (sr[7:1] == TGT_ADDR) begin
                sda_low <= 1'b1;
                start_o <= 1'b1;
                busy_o  <= 1'b1;
                rw      <= sr[0];
                state   <= A_ACK;
              end else begin
                state   <= IGNORE;
              end
            end
            A_ACK: if (rw) begin
              tx_req_o <= 1'b1;
              sr       <= tx_data_i;
              sda_low  <= ~tx_data_i[7];
              cnt      <= 3'd0;
              state    <= RDATA;
            end else begin
              sda_low  <= 1'b0;
              cnt      <= 3'd0;
              state    <= WDATA;
            end
            WDATA: if (full) begin
              full       <= 1'b0;
              rx_data_o  <= sr;
              rx_valid_o <= 1'b1;
              sda_low    <= rx_ready_i;
              acked      <= rx_ready_i;
              state      <= W_ACK;
            end
            W_ACK: begin
              sda_low <= 1'b0;
              if (acked) begin
                state  <= WDATA;
              end else begin
                state  <= IGNORE;
                busy_o <= 1'b0;
              end
            end
            RDATA: if (full) begin
              full    <= 1'b0;
              sda_low <= 1'b0;
              state   <= R_ACK;
            end else begin
              sda_low <= ~sr[rbit];
            end
            R_ACK: if (mack) begin
              tx_req_o <= 1'b1;
              sr       <= tx_data_i;
              sda_low  <= ~tx_data_i[7];
              cnt      <= 3'd0;
              state    <= RDATA;
            end else begin
              sda_low  <= 1'b0;
              busy_o   <= 1'b0;
              state    <= IGNORE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed bench for i2c_target with a bit-banged open-drain initiator
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_sda, m_scl;
  wire        sda_bus, scl_bus;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, tx_req, start_p, stop_p, busy;
  logic [7:0] tx_data;

  assign sda_bus = m_sda ? 1'bz : 1'b0;
  assign scl_bus = m_scl ? 1'bz : 1'b0;
  pullup (sda_bus);
  pullup (scl_bus);

  always #5 clk = ~clk;

  i2c_target #(.TGT_ADDR(7'h50)) dut (
    .clk_i(clk), .rst_i(rst_n), .sda_io(sda_bus), .scl_io(scl_bus),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .tx_data_i(tx_data), .tx_req_o(tx_req), .start_o(start_p),
    .stop_o(stop_p), .busy_o(busy)
  );

  int c_start = 0, c_stop = 0, c_rx = 0, c_tx = 0, c_low = 0, c_busy = 0;
  always @(negedge clk) begin
    if (start_p) c_start++;
    if (stop_p) c_stop++;
    if (rx_valid) c_rx++;
    if (tx_req) c_tx++;
    if (busy) c_busy++;
    if (!sda_bus && m_sda) c_low++;
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_bit(input logic b, output logic s);
    m_sda = b;
    wait_clk(8);
    m_scl = 1'b1;
    wait_clk(8);
    s = sda_bus;
    wait_clk(8);
    m_scl = 1'b0;
    wait_clk(8);
  endtask

  task automatic m_start;
    m_sda = 1'b1;
    wait_clk(8);
    m_scl = 1'b1;
    wait_clk(8);
    m_sda = 1'b0;
    wait_clk(8);
    m_scl = 1'b0;
    wait_clk(8);
  endtask

  task automatic m_stop;
    m_sda = 1'b0;
    wait_clk(8);
    m_scl = 1'b1;
    wait_clk(8);
    m_sda = 1'b1;
    wait_clk(8);
  endtask

  task automatic m_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(d[i], s);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read8(output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rdy;
    logic       exp_aack;
    logic       exp_dack;
    int         exp_start;
    int         exp_rx;
    logic [7:0] exp_rxd;
    int         exp_stop;
  } vec_t;

  vec_t v[6];

  initial begin
    logic       aack, dack, s;
    logic [7:0] rd;
    int         b_start, b_stop, b_rx, b_tx, b_low, b_busy;

    v[0] = '{8'hA0, 8'hA5, 1'b1, 1'b0, 1'b0, 1, 1, 8'hA5, 1};
    v[1] = '{8'hA2, 8'h12, 1'b1, 1'b1, 1'b1, 0, 0, 8'hA5, 0};
    v[2] = '{8'hA0, 8'h77, 1'b0, 1'b0, 1'b1, 1, 1, 8'h77, 0};
    v[3] = '{8'h00, 8'h55, 1'b1, 1'b1, 1'b1, 0, 0, 8'h77, 0};
    v[4] = '{8'hA0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1, 8'h00, 1};
    v[5] = '{8'hA0, 8'hFF, 1'b1, 1'b0, 1'b0, 1, 1, 8'hFF, 1};

    m_sda = 1'b1; m_scl = 1'b1; rx_ready = 1'b1; tx_data = 8'h00; rst_n = 1'b0;
    wait_clk(5);
    check("reset sda", sda_bus, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset pulses", {start_p, stop_p, rx_valid, tx_req}, 4'h0);
    rst_n = 1'b1;
    wait_clk(5);

    for (int i = 0; i < 6; i++) begin
      b_start = c_start; b_stop = c_stop; b_rx = c_rx; b_low = c_low;
      rx_ready = v[i].rdy;
      m_start;
      m_byte(v[i].addr, aack);
      m_byte(v[i].data, dack);
      m_stop;
      wait_clk(6);
      check($sformatf("v%0d addr ack", i), aack, v[i].exp_aack);
      check($sformatf("v%0d data ack", i), dack, v[i].exp_dack);
      check($sformatf("v%0d start_o", i), c_start - b_start, v[i].exp_start);
      check($sformatf("v%0d rx_valid_o", i), c_rx - b_rx, v[i].exp_rx);
      check($sformatf("v%0d rx_data_o", i), rx_data, v[i].exp_rxd);
      check($sformatf("v%0d stop_o", i), c_stop - b_stop, v[i].exp_stop);
      check($sformatf("v%0d sda pulled", i), (c_low - b_low) > 0, !v[i].exp_aack || !v[i].exp_dack);
      check($sformatf("v%0d busy after", i), busy, 1'b0);
    end

    // NACKed byte: the following byte must be ignored
    b_rx = c_rx; b_stop = c_stop;
    rx_ready = 1'b0;
    m_start;
    m_byte(8'hA0, aack);
    m_byte(8'h77, dack);
    check("nack busy cleared", busy, 1'b0);
    rx_ready = 1'b1;
    m_byte(8'h11, dack);
    m_stop;
    wait_clk(6);
    check("nack next byte ack", dack, 1'b1);
    check("nack rx count", c_rx - b_rx, 1);
    check("nack rx_data", rx_data, 8'h77);
    check("nack stop_o", c_stop - b_stop, 0);

    // read two bytes, ACK then NACK
    b_start = c_start; b_stop = c_stop; b_tx = c_tx; b_busy = c_busy;
    tx_data = 8'h3C;
    m_start;
    m_byte(8'hA1, aack);
    check("read addr ack", aack, 1'b0);
    m_read8(rd);
    check("read byte0", rd, 8'h3C);
    tx_data = 8'hC3;
    m_bit(1'b0, s);
    m_read8(rd);
    check("read byte1", rd, 8'hC3);
    tx_data = 8'h00;
    m_bit(1'b1, s);
    wait_clk(6);
    check("read busy after nack", busy, 1'b0);
    check("read tx_req count", c_tx - b_tx, 2);
    m_stop;
    wait_clk(6);
    check("read start_o", c_start - b_start, 1);
    check("read stop_o", c_stop - b_stop, 0);
    check("read busy seen", c_busy > b_busy, 1'b1);

    // partial write then repeated START into a read
    b_start = c_start; b_rx = c_rx; b_tx = c_tx;
    tx_data = 8'h99;
    m_start;
    m_byte(8'hA0, aack);
    m_bit(1'b1, s); m_bit(1'b0, s); m_bit(1'b1, s); m_bit(1'b0, s);
    m_start;
    check("rs busy cleared", busy, 1'b0);
    m_byte(8'hA1, aack);
    check("rs read addr ack", aack, 1'b0);
    m_read8(rd);
    m_bit(1'b1, s);
    m_stop;
    wait_clk(6);
    check("rs read byte", rd, 8'h99);
    check("rs rx_valid", c_rx - b_rx, 0);
    check("rs start_o", c_start - b_start, 2);
    check("rs tx_req", c_tx - b_tx, 1);

    // asynchronous reset while the address ACK holds SDA low
    m_start;
    for (int i = 7; i >= 0; i--) m_bit(logic'((8'hA0 >> i) & 1), s);
    m_sda = 1'b1;
    wait_clk(8);
    check("ack sda low before reset", sda_bus, 1'b0);
    check("busy before reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("sda released on reset", sda_bus, 1'b1);
    check("busy on reset", busy, 1'b0);
    check("rx_data on reset", rx_data, 8'h00);
    m_scl = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    b_rx = c_rx; b_start = c_start;
    rx_ready = 1'b1;
    m_start;
    m_byte(8'hA0, aack);
    m_byte(8'h42, dack);
    m_stop;
    wait_clk(6);
    check("post reset addr ack", aack, 1'b0);
    check("post reset data ack", dack, 1'b0);
    check("post reset rx_data", rx_data, 8'h42);
    check("post reset counts", {c_rx - b_rx, c_start - b_start}, {32'd1, 32'd1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
